// File: rtl/instruction_fetch_unit.sv
// Fetch stage: issues the PC to a 1-cycle synchronous instruction memory and presents the IF/ID boundary.
// Optional performance counters are built when IFU_PERF_EN is defined.
module instruction_fetch_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] imem_instr,
  output logic [31:0] imem_pc,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [31:0] if_instr,
`ifdef IFU_PERF_EN
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count,
`endif
  output logic        if_valid
);

  localparam int unsigned XLEN      = 32;
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

  state_t          state;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] fpc_q;
  logic            fvalid_q;
  logic [XLEN-1:0] hold_q;

  // Redirect overrides stall; fpc_q is left alone on redirect since the slot is marked invalid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RUN;
      pc_q     <= RESET_PC;
      fpc_q    <= RESET_PC;
      fvalid_q <= 1'b0;
      hold_q   <= '0;
    end else if (redirect) begin
      pc_q     <= redirect_pc;
      fvalid_q <= 1'b0;
      state    <= RUN;
    end else begin
      case (state)
        RUN: begin
          if (stall) begin
            hold_q <= imem_instr;
            state  <= HOLD;
          end else begin
            fpc_q    <= pc_q;
            fvalid_q <= 1'b1;
            pc_q     <= pc_q + PC_STEP;
          end
        end
        HOLD: begin
          // Memory has already re-read pc_q, so leaving HOLD costs no bubble.
          if (!stall) begin
            fpc_q    <= pc_q;
            fvalid_q <= 1'b1;
            pc_q     <= pc_q + PC_STEP;
            state    <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign imem_pc     = pc_q;
  assign if_pc       = fpc_q;
  assign if_pc_plus4 = fpc_q + PC_STEP;
  assign if_valid    = fvalid_q;
  assign if_instr    = !fvalid_q       ? NOP_INSTR :
                       (state == HOLD) ? hold_q    : imem_instr;

`ifdef IFU_PERF_EN
  // Retired-fetch and bubble counters, both free-running modulo 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_count  <= '0;
      bubble_count <= '0;
    end else begin
      if (fvalid_q && !stall) fetch_count <= fetch_count + 32'd1;
      if (!fvalid_q)          bubble_count <= bubble_count + 32'd1;
    end
  end
`endif

endmodule
